// File: rtl/path_reporter_if.sv
// Replay stream of the path reporter: one location per handshake, start cell first.
interface path_reporter_if #(
  parameter int unsigned LOC_W = 8
);
  logic             outValid;
  logic             outReady;
  logic [LOC_W-1:0] outLoc;
  logic [1:0]       outDir;
  logic             outFirst;
  logic             outLast;

  modport master (
    output outValid, outLoc, outDir, outFirst, outLast,
    input  outReady
  );

  modport slave (
    input  outValid, outLoc, outDir, outFirst, outLast,
    output outReady
  );
endinterface

// File: rtl/path_reporter.sv
// Captures the solver's destination-first stack pops and replays them start-first with move directions.
// Optional PATH_REPORTER_LEN_EN adds the pathLen output (captured path length).
module path_reporter #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned LOC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic             fail,
  input  logic             capEn,
  input  logic [LOC_W-1:0] locIn,
  input  logic             empStck,
  path_reporter_if.master  rep,
  output logic             pathDone,
  output logic             ovf,
  output logic             dirErr,
`ifdef PATH_REPORTER_LEN_EN
  output logic [AW:0]      pathLen,
`endif
  output logic             busy
);

  localparam int unsigned HW = LOC_W / 2;
  localparam logic [HW:0] P1 = (HW+1)'(1);
  localparam logic [HW:0] N1 = '1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY, FINISH} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      count;
  logic [AW-1:0]    ptr;
  logic             valid_q;
  logic [LOC_W-1:0] mem [DEPTH];

  logic [LOC_W-1:0] cur, prev;
  logic [AW-1:0]    prev_idx;
  logic             first, last, adj, hs, store;
  logic [HW:0]      drow, dcol;
  logic [1:0]       dir;

  // Buffer read side: current element plus its predecessor in replay order
  always_comb begin
    cur      = mem[ptr];
    first    = ({1'b0, ptr} == (count - (AW+1)'(1)));
    last     = (ptr == '0);
    prev_idx = first ? ptr : ptr + AW'(1);
    prev     = mem[prev_idx];
    drow     = {1'b0, cur[LOC_W-1:HW]} - {1'b0, prev[LOC_W-1:HW]};
    dcol     = {1'b0, cur[HW-1:0]} - {1'b0, prev[HW-1:0]};
    hs       = valid_q & rep.outReady;
    store    = (state_q == CAPTURE) && !fail && capEn && (count < DEPTH_C);
  end

  // Move classification; anything other than a single 4-neighbour step reports 00
  always_comb begin
    dir = 2'b00;
    adj = 1'b0;
    if (dcol == '0 && drow == N1) begin
      dir = 2'b00; adj = 1'b1;
    end else if (drow == '0 && dcol == P1) begin
      dir = 2'b01; adj = 1'b1;
    end else if (dcol == '0 && drow == P1) begin
      dir = 2'b10; adj = 1'b1;
    end else if (drow == '0 && dcol == N1) begin
      dir = 2'b11; adj = 1'b1;
    end
  end

  assign rep.outValid = valid_q;
  assign rep.outLoc   = valid_q ? cur : '0;
  assign rep.outFirst = valid_q & first;
  assign rep.outLast  = valid_q & last;
  assign rep.outDir   = (valid_q && !first && adj) ? dir : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (done) state_d = CAPTURE;
      CAPTURE: begin
        if (fail)                  state_d = IDLE;
        else if (!capEn && empStck) state_d = (count == '0) ? FINISH : REPLAY;
      end
      REPLAY:  if (hs && last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture buffer needs no reset; contents are only read after being written
  always_ff @(posedge clk) begin
    if (store) mem[count[AW-1:0]] <= locIn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      ptr      <= '0;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      pathDone <= 1'b0;
      ovf      <= 1'b0;
      dirErr   <= 1'b0;
`ifdef PATH_REPORTER_LEN_EN
      pathLen  <= '0;
`endif
    end else begin
      valid_q  <= (state_d == REPLAY);
      busy     <= (state_d != IDLE);
      pathDone <= (state_d == FINISH);
      case (state_q)
        IDLE: if (done) begin
          count  <= '0;
          ovf    <= 1'b0;
          dirErr <= 1'b0;
        end
        CAPTURE: begin
          if (fail) begin
            count <= '0;
          end else if (capEn) begin
            if (count < DEPTH_C) count <= count + (AW+1)'(1);
            else                 ovf   <= 1'b1;
          end else if (empStck) begin
            ptr <= AW'(count - (AW+1)'(1));
`ifdef PATH_REPORTER_LEN_EN
            // count never exceeds DEPTH, so an overflowed capture reports DEPTH
            pathLen <= count;
`endif
          end
        end
        REPLAY: if (hs) begin
          ptr <= ptr - AW'(1);
          if (!first && !adj) dirErr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
